// File: rtl/pipe_stage_chain.sv
// rtl/pipe_stage_chain.sv - elastic valid/ready register chain with hold and flush
// PIPE_SKID_EN adds a 2-entry skid FIFO behind the last stage to break the out_ready -> in_ready path.
module pipe_stage_chain #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              hold,
  input  logic              flush,
  output logic [CNT_W-1:0]  occupancy
);
  localparam int LAST = DEPTH - 1;

  logic [DEPTH-1:0]  v;
  logic [DATA_W-1:0] d   [DEPTH];
  logic [DATA_W-1:0] src [DEPTH];
  logic [DEPTH-1:0]  adv;
  logic [DEPTH-1:0]  load;
  logic              run;
  logic              sink_ok;
  logic              in_ok;
  logic              in_fire;
  logic              out_fire;

  assign run = !hold && !flush;

`ifdef PIPE_SKID_EN
  logic [DATA_W-1:0] sk_mem [2];
  logic              sk_wp;
  logic              sk_rp;
  logic [1:0]        sk_cnt;

  // Only the registered skid count gates the last stage, so out_ready never reaches in_ready.
  assign sink_ok   = run && (sk_cnt != 2'd2);
  assign out_valid = run && (sk_cnt != 2'd0);
  assign out_data  = sk_mem[sk_rp];
`else
  assign sink_ok   = run && out_ready;
  assign out_valid = run && v[LAST];
  assign out_data  = d[LAST];
`endif

  assign out_fire = out_valid && out_ready;
  assign in_ready = in_ok;
  assign in_fire  = in_valid && in_ok;

  // Walk from the output back to the input: a stage may advance if its sink is free or leaving.
  always_comb begin
    logic nxt;
    logic a;
    adv = '0;
    nxt = sink_ok;
    for (int k = LAST; k >= 0; k--) begin
      a      = v[k] & nxt;
      adv[k] = a;
      nxt    = run & (!v[k] | a);
    end
    in_ok = nxt;
  end

  always_comb begin
    load    = '0;
    load[0] = in_fire;
    src[0]  = in_data;
    for (int k = 1; k < DEPTH; k++) begin
      load[k] = adv[k-1];
      src[k]  = d[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v <= '0;
      for (int k = 0; k < DEPTH; k++) d[k] <= '0;
    end else if (flush) begin
      v <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        v[k] <= load[k] | (v[k] & !adv[k]);
        if (load[k]) d[k] <= src[k];
      end
    end
  end

`ifdef PIPE_SKID_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      sk_cnt    <= 2'd0;
      sk_wp     <= 1'b0;
      sk_rp     <= 1'b0;
      sk_mem[0] <= '0;
      sk_mem[1] <= '0;
    end else if (flush) begin
      sk_cnt <= 2'd0;
      sk_wp  <= 1'b0;
      sk_rp  <= 1'b0;
    end else begin
      if (adv[LAST]) begin
        sk_mem[sk_wp] <= d[LAST];
        sk_wp         <= ~sk_wp;
      end
      if (out_fire) sk_rp <= ~sk_rp;
      sk_cnt <= sk_cnt + {1'b0, adv[LAST]} - {1'b0, out_fire};
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset || flush) occupancy <= '0;
    else                occupancy <= occupancy + CNT_W'(in_fire) - CNT_W'(out_fire);
  end
endmodule

// File: tb/tb_pipe_stage_chain.sv
// tb/tb_pipe_stage_chain.sv - directed bench for pipe_stage_chain against a positional queue model
// Runs DEPTH=3 without PIPE_SKID_EN and DEPTH=1 with it.
module tb_pipe_stage_chain;
`ifdef PIPE_SKID_EN
  localparam int DEPTH = 1;
  localparam int LIMIT = DEPTH;
`else
  localparam int DEPTH = 3;
  localparam int LIMIT = DEPTH - 1;
`endif
  localparam int DW    = 32;
  localparam int CNT_W = 4;

  logic clk, reset, in_valid, in_ready, out_valid, out_ready, hold, flush;
  logic [DW-1:0]    in_data, out_data;
  logic [CNT_W-1:0] occupancy;

  pipe_stage_chain #(.DATA_W(DW), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .hold(hold), .flush(flush), .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int chk_cnt = 0;
  int pass_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    chk_cnt++;
    if (act === want) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, want);
  endtask

  // Model: queue of entries, oldest first, each with a position (0..DEPTH-1 stages, DEPTH = skid).
  logic [31:0] qdat[$];
  int          qpos[$];
  logic [31:0] m_dlast = '0;
  bit          mv[16];
  bit          m_in_ready, m_out_valid;
  logic [31:0] got[$];

  function automatic void model_eval();
    bit run;
    bit leave;
    int sk;
    run = !hold && !flush;
    sk = 0;
    foreach (qpos[i]) if (qpos[i] == DEPTH) sk++;
`ifdef PIPE_SKID_EN
    m_out_valid = run && (sk > 0);
`else
    m_out_valid = run && (qpos.size() > 0) && (qpos[0] == DEPTH - 1);
`endif
    leave = m_out_valid && out_ready;
    for (int i = 0; i < qpos.size(); i++) begin
      if (!run) mv[i] = 1'b0;
      else if (qpos[i] == DEPTH) mv[i] = (i == 0) && leave;
      else if (qpos[i] == DEPTH - 1) begin
`ifdef PIPE_SKID_EN
        mv[i] = (sk < 2);
`else
        mv[i] = leave;
`endif
      end
      else if (i == 0) mv[i] = 1'b1;
      else mv[i] = (qpos[i-1] > qpos[i] + 1) || mv[i-1];
    end
    m_in_ready = run && (qpos.size() == 0 || qpos[qpos.size()-1] != 0 || mv[qpos.size()-1]);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      qdat.delete(); qpos.delete(); m_dlast = '0;
    end else if (flush) begin
      qdat.delete(); qpos.delete();
    end else begin
      model_eval();
      for (int i = 0; i < qpos.size(); i++)
        if (mv[i]) begin
          qpos[i] = qpos[i] + 1;
          if (qpos[i] == DEPTH - 1) m_dlast = qdat[i];
        end
      if (qpos.size() > 0 && qpos[0] > LIMIT) begin
        void'(qpos.pop_front()); void'(qdat.pop_front());
      end
      if (in_valid && m_in_ready) begin
        qpos.push_back(0); qdat.push_back(in_data);
        if (DEPTH == 1) m_dlast = in_data;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      model_eval();
      check("in_ready", 32'(in_ready), 32'(m_in_ready));
      check("out_valid", 32'(out_valid), 32'(m_out_valid));
      check("occupancy", 32'(occupancy), 32'(qdat.size()));
`ifdef PIPE_SKID_EN
      if (m_out_valid) check("out_data", out_data, qdat[0]);
`else
      check("out_data", out_data, m_dlast);
`endif
      if (out_valid && out_ready) got.push_back(out_data);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] exp_seq [4];
  logic [31:0] w;
  logic [31:0] sent[$];
  bit acc;

  initial begin
    reset = 1; in_valid = 0; in_data = '0; out_ready = 1; hold = 0; flush = 0;
    tick(); tick();
    reset = 0;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_occupancy", 32'(occupancy), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    tick();
`ifndef PIPE_SKID_EN
    // Streaming, latency 3
    got.delete(); in_valid = 1; in_data = 32'h11;
    @(negedge clk); check("t1_accept", 32'(in_ready), 32'd1); tick();
    in_data = 32'h22; tick();
    in_data = 32'h33;
    @(negedge clk); check("t1_not_yet_valid", 32'(out_valid), 32'd0); tick();
    in_data = 32'h44;
    @(negedge clk);
    check("t1_first_valid", 32'(out_valid), 32'd1);
    check("t1_first_data", out_data, 32'h11);
    check("t1_occ_a", 32'(occupancy), 32'd3);
    tick();
    in_valid = 0;
    @(negedge clk);
    check("t1_occ_b", 32'(occupancy), 32'd3);
    check("t1_second_data", out_data, 32'h22);
    tick();
    repeat (6) tick();
    exp_seq[0] = 32'h11; exp_seq[1] = 32'h22; exp_seq[2] = 32'h33; exp_seq[3] = 32'h44;
    check("t1_count", 32'(got.size()), 32'd4);
    for (int i = 0; i < 4 && i < got.size(); i++) check("t1_order", got[i], exp_seq[i]);

    // Backpressure
    got.delete(); out_ready = 0; in_valid = 1; w = 32'h51;
    for (int i = 0; i < 5; i++) begin
      in_data = w;
      @(negedge clk); acc = in_ready;
      tick();
      if (acc) w = w + 1;
    end
    check("t2_accepted", w, 32'h54);
    in_data = w;
    @(negedge clk);
    check("t2_full_in_ready", 32'(in_ready), 32'd0);
    check("t2_full_occ", 32'(occupancy), 32'd3);
    check("t2_full_out_valid", 32'(out_valid), 32'd1);
    check("t2_full_out_data", out_data, 32'h51);
    tick();
    out_ready = 1;
    @(negedge clk); check("t2_release_in_ready", 32'(in_ready), 32'd1); tick();
    in_valid = 0;
    @(negedge clk);
    check("t2_release_occ", 32'(occupancy), 32'd3);
    check("t2_release_data", out_data, 32'h52);
    tick();
    repeat (6) tick();
    exp_seq[0] = 32'h51; exp_seq[1] = 32'h52; exp_seq[2] = 32'h53; exp_seq[3] = 32'h54;
    check("t2_count", 32'(got.size()), 32'd4);
    for (int i = 0; i < 4 && i < got.size(); i++) check("t2_order", got[i], exp_seq[i]);

    // Hold
    got.delete(); out_ready = 0; in_valid = 1; in_data = 32'hA; tick();
    in_data = 32'hB; tick();
    in_valid = 0; tick();
    hold = 1; in_valid = 1; in_data = 32'hC; out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t3_hold_in_ready", 32'(in_ready), 32'd0);
      check("t3_hold_out_valid", 32'(out_valid), 32'd0);
      check("t3_hold_occ", 32'(occupancy), 32'd2);
      check("t3_hold_data", out_data, 32'hA);
      tick();
    end
    hold = 0; in_valid = 0;
    @(negedge clk); check("t3_first", out_data, 32'hA); check("t3_first_v", 32'(out_valid), 32'd1); tick();
    @(negedge clk); check("t3_second", out_data, 32'hB); check("t3_second_v", 32'(out_valid), 32'd1); tick();
    repeat (4) tick();
    check("t3_count", 32'(got.size()), 32'd2);

    // Flush with hold and an offered word
    got.delete(); out_ready = 0; in_valid = 1;
    in_data = 32'h61; tick(); in_data = 32'h62; tick(); in_data = 32'h63; tick();
    flush = 1; hold = 1; in_data = 32'h99;
    @(negedge clk);
    check("t4_flush_in_ready", 32'(in_ready), 32'd0);
    check("t4_flush_out_valid", 32'(out_valid), 32'd0);
    tick();
    flush = 0; hold = 0; in_valid = 0; out_ready = 1;
    @(negedge clk);
    check("t4_occ", 32'(occupancy), 32'd0);
    check("t4_out_valid", 32'(out_valid), 32'd0);
    check("t4_data_kept", out_data, 32'h61);
    tick();
    repeat (4) tick();
    check("t4_nothing_out", 32'(got.size()), 32'd0);

    // Reset mid-transfer with hold
    out_ready = 0; in_valid = 1;
    in_data = 32'hDEADBEEF; tick(); in_data = 32'h1; tick(); in_data = 32'h2; tick();
    in_data = 32'h3; out_ready = 1; reset = 1; hold = 1;
    @(negedge clk); check("t5_last_before", out_data, 32'hDEADBEEF);
    tick();
    reset = 0; hold = 0; in_valid = 0;
    @(negedge clk);
    check("t5_out_valid", 32'(out_valid), 32'd0);
    check("t5_out_data", out_data, 32'd0);
    check("t5_occ", 32'(occupancy), 32'd0);
    check("t5_in_ready", 32'(in_ready), 32'd1);
    tick();
`else
    // Skid latency: DEPTH+1
    got.delete(); out_ready = 1; in_valid = 1; in_data = 32'h70; tick();
    in_valid = 0;
    @(negedge clk); check("sk_lat_early", 32'(out_valid), 32'd0); tick();
    @(negedge clk); check("sk_lat_valid", 32'(out_valid), 32'd1); check("sk_lat_data", out_data, 32'h70); tick();
    tick();
    // Toggling out_ready with continuous input
    got.delete(); sent.delete(); in_valid = 1; w = 32'h71;
    for (int i = 0; i < 16; i++) begin
      out_ready = (i % 2 == 0);
      in_data = w;
      @(negedge clk);
      acc = in_ready;
      check("sk_occ_max", 32'(occupancy <= 3), 32'd1);
      #1 out_ready = !out_ready;
      #1 check("sk_in_ready_indep", 32'(in_ready), 32'(acc));
      out_ready = !out_ready;
      tick();
      if (acc) begin sent.push_back(w); w = w + 1; end
    end
    in_valid = 0; out_ready = 1;
    repeat (8) tick();
    check("sk_count", 32'(got.size()), 32'(sent.size()));
    for (int i = 0; i < sent.size() && i < got.size(); i++) check("sk_order", got[i], sent[i]);
    if (got.size() > 0) check("sk_first_word", got[0], 32'h71);
`endif
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
